// File: rtl/synarray_sched.sv
// Arbitrates the 8192x32 synaptic SRAM between SPI byte accesses and learning read-modify-write sweeps.
// SPI access: ACK 3 cycles after request; sweep: 2 cycles/word; SPI waits for gate=1 at IDLE or a word boundary.
module synarray_sched #(
    parameter int ADDR_W = 13
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SPI_GATE_ACTIVITY_sync,
    input  logic              SPI_REQ,
    input  logic              SPI_WR,
    input  logic [ADDR_W+1:0] SPI_ADDR,
    output logic              SPI_ACK,
    output logic [7:0]        SPI_RDATA,
    input  logic              UPD_START,
    input  logic [ADDR_W-1:0] UPD_BASE,
    input  logic [ADDR_W-1:0] UPD_LEN,
    input  logic [7:0]        UPD_PRE_EN,
    output logic              UPD_BUSY,
    output logic              UPD_DONE,
    input  logic [31:0]       SYNARRAY_RDATA,
    output logic              CTRL_SYNARRAY_CS,
    output logic              CTRL_SYNARRAY_WE,
    output logic [ADDR_W-1:0] CTRL_SYNARRAY_ADDR,
    output logic [7:0]        CTRL_PRE_EN,
    output logic [1:0]        CTRL_SPI_ADDR
);

    typedef enum logic [3:0] {
        IDLE, S_RD, S_WR, S_RWAIT, S_ACK, U_RD, U_WR, U_SUSP, U_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_from_susp;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_word;
    logic              r_wr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [7:0]        r_pre_en;
    logic [7:0]        r_rdata;

    logic              w_spi_go;
    logic              w_upd_go;
    logic              w_spi_accept;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_last;
    logic [ADDR_W-1:0] w_uaddr;
    logic [7:0]        w_byte;

    assign w_spi_go     = SPI_REQ && SPI_GATE_ACTIVITY_sync;
    assign w_upd_go     = UPD_START && !SPI_GATE_ACTIVITY_sync;
    assign w_spi_accept = w_spi_go && (r_state == IDLE || r_state == U_SUSP);
    assign w_cnt_nxt    = r_cnt + ADDR_W'(1);
    assign w_last       = (w_cnt_nxt == r_len);
    assign w_uaddr      = r_base + r_cnt;   // wraps modulo the array size

    always_comb begin
        w_byte = SYNARRAY_RDATA[7:0];
        case (r_lane)
            2'd1:    w_byte = SYNARRAY_RDATA[15:8];
            2'd2:    w_byte = SYNARRAY_RDATA[23:16];
            2'd3:    w_byte = SYNARRAY_RDATA[31:24];
            default: w_byte = SYNARRAY_RDATA[7:0];
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_spi_go)      w_next = S_RD;
                else if (w_upd_go) w_next = (UPD_LEN == '0) ? U_DONE : U_RD;
            end
            S_RD:    w_next = r_wr ? S_WR : S_RWAIT;
            S_WR:    w_next = S_ACK;
            S_RWAIT: w_next = S_ACK;
            S_ACK:   w_next = r_from_susp ? U_SUSP : IDLE;
            U_RD:    w_next = U_WR;
            // A gate rise only takes effect here, so a word RMW is never split.
            U_WR: begin
                if (w_last)                      w_next = U_DONE;
                else if (SPI_GATE_ACTIVITY_sync) w_next = U_SUSP;
                else                             w_next = U_RD;
            end
            U_SUSP: begin
                if (w_spi_go)                     w_next = S_RD;
                else if (!SPI_GATE_ACTIVITY_sync) w_next = U_RD;
            end
            U_DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_from_susp <= 1'b0;
            r_lane      <= '0;
            r_word      <= '0;
            r_wr        <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_pre_en    <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_spi_accept) begin
                r_lane      <= SPI_ADDR[ADDR_W+1:ADDR_W];
                r_word      <= SPI_ADDR[ADDR_W-1:0];
                r_wr        <= SPI_WR;
                r_from_susp <= (r_state == U_SUSP);
            end
            if (r_state == IDLE && !w_spi_go && w_upd_go) begin
                r_base   <= UPD_BASE;
                r_len    <= UPD_LEN;
                r_pre_en <= UPD_PRE_EN;
                r_cnt    <= '0;
            end
            if (r_state == U_WR) begin
                r_cnt <= w_cnt_nxt;
            end
            if (r_state == S_RWAIT) begin
                r_rdata <= w_byte;
            end
        end
    end

    assign SPI_RDATA = r_rdata;

    always_comb begin
        SPI_ACK            = 1'b0;
        UPD_BUSY           = 1'b0;
        UPD_DONE           = 1'b0;
        CTRL_SYNARRAY_CS   = 1'b0;
        CTRL_SYNARRAY_WE   = 1'b0;
        CTRL_SYNARRAY_ADDR = '0;
        CTRL_PRE_EN        = '0;
        CTRL_SPI_ADDR      = '0;
        case (r_state)
            S_RD: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_ADDR = r_word;
                CTRL_SPI_ADDR      = r_lane;
                UPD_BUSY           = r_from_susp;
            end
            S_WR: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_WE   = 1'b1;
                CTRL_SYNARRAY_ADDR = r_word;
                CTRL_SPI_ADDR      = r_lane;
                UPD_BUSY           = r_from_susp;
            end
            S_RWAIT: begin
                CTRL_SPI_ADDR = r_lane;
                UPD_BUSY      = r_from_susp;
            end
            S_ACK: begin
                SPI_ACK       = 1'b1;
                CTRL_SPI_ADDR = r_lane;
                UPD_BUSY      = r_from_susp;
            end
            U_RD: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_ADDR = w_uaddr;
                UPD_BUSY           = 1'b1;
            end
            U_WR: begin
                CTRL_SYNARRAY_CS   = 1'b1;
                CTRL_SYNARRAY_WE   = 1'b1;
                CTRL_SYNARRAY_ADDR = w_uaddr;
                CTRL_PRE_EN        = r_pre_en;
                UPD_BUSY           = 1'b1;
            end
            U_SUSP: UPD_BUSY = 1'b1;
            U_DONE: begin
                UPD_DONE = 1'b1;
                UPD_BUSY = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_synarray_sched.sv
// Bench for synarray_sched: directed and randomized SPI accesses and sweeps against expected traces
// derived from the access rules (cycle-of-access arithmetic, expected write-address lists, SRAM array model).
module tb_synarray_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        gate;
    logic        SPI_REQ;
    logic        SPI_WR;
    logic [14:0] SPI_ADDR;
    logic        SPI_ACK;
    logic [7:0]  SPI_RDATA;
    logic        UPD_START;
    logic [12:0] UPD_BASE;
    logic [12:0] UPD_LEN;
    logic [7:0]  UPD_PRE_EN;
    logic        UPD_BUSY;
    logic        UPD_DONE;
    logic [31:0] q;
    logic        CS;
    logic        WE;
    logic [12:0] ADDR;
    logic [7:0]  PRE_EN;
    logic [1:0]  LANE;

    always #5 CLK = ~CLK;

    synarray_sched #(.ADDR_W(13)) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .SPI_GATE_ACTIVITY_sync (gate),
        .SPI_REQ                (SPI_REQ),
        .SPI_WR                 (SPI_WR),
        .SPI_ADDR               (SPI_ADDR),
        .SPI_ACK                (SPI_ACK),
        .SPI_RDATA              (SPI_RDATA),
        .UPD_START              (UPD_START),
        .UPD_BASE               (UPD_BASE),
        .UPD_LEN                (UPD_LEN),
        .UPD_PRE_EN             (UPD_PRE_EN),
        .UPD_BUSY               (UPD_BUSY),
        .UPD_DONE               (UPD_DONE),
        .SYNARRAY_RDATA         (q),
        .CTRL_SYNARRAY_CS       (CS),
        .CTRL_SYNARRAY_WE       (WE),
        .CTRL_SYNARRAY_ADDR     (ADDR),
        .CTRL_PRE_EN            (PRE_EN),
        .CTRL_SPI_ADDR          (LANE)
    );

    // SRAM model: registered read data; write data belongs to the core and is not modelled.
    logic [31:0] mem [0:8191];
    always @(posedge CLK) begin
        if (CS && !WE) q <= mem[ADDR];
    end

    int checks = 0;
    int errors = 0;
    int n_ack  = 0;
    int n_done = 0;
    int n_cs   = 0;
    logic [12:0] wr_log [$];
    logic [7:0]  pe_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        if (CS) n_cs++;
        if (CS && WE) begin
            wr_log.push_back(ADDR);
            pe_log.push_back(PRE_EN);
        end
        if (SPI_ACK)  n_ack++;
        if (UPD_DONE) n_done++;
    endtask

    task automatic spi_op(input logic wr, input logic [1:0] lane, input logic [12:0] a, input logic busy);
        logic [31:0] w;
        logic [7:0]  eb;
        w  = mem[a];
        eb = w[8*lane +: 8];
        SPI_REQ  = 1'b1;
        SPI_WR   = wr;
        SPI_ADDR = {lane, a};
        step();
        chk("spi_c1", {CS, WE, ADDR, LANE, SPI_ACK, UPD_BUSY}, {1'b1, 1'b0, a, lane, 1'b0, busy});
        step();
        chk("spi_c2", {CS, WE, SPI_ACK, LANE, UPD_BUSY}, {wr, wr, 1'b0, lane, busy});
        if (wr) chk("spi_c2_addr", 64'(ADDR), 64'(a));
        step();
        chk("spi_ack", {CS, SPI_ACK, LANE, UPD_BUSY}, {1'b0, 1'b1, lane, busy});
        if (!wr) chk("spi_rdata", 64'(SPI_RDATA), 64'(eb));
        SPI_REQ = 1'b0;
        step();
        chk("spi_ack_once", 64'(SPI_ACK), 64'(0));
    endtask

    task automatic sweep(input logic [12:0] base, input logic [12:0] len, input logic [7:0] pe, input logic poke);
        int          n;
        logic        ecs;
        logic        ewe;
        logic [12:0] eaddr;
        logic [12:0] oaddr;
        n          = 2 * int'(len) + 1;
        gate       = 1'b0;
        UPD_START  = 1'b1;
        UPD_BASE   = base;
        UPD_LEN    = len;
        UPD_PRE_EN = pe;
        step();
        UPD_START = 1'b0;
        for (int k = 1; k <= n; k++) begin
            ecs   = (k <= 2 * int'(len));
            ewe   = ecs && (k % 2 == 0);
            eaddr = ecs ? 13'(int'(base) + (k - 1) / 2) : 13'd0;
            oaddr = CS ? ADDR : 13'd0;
            chk("sweep_cycle", {CS, WE, oaddr, PRE_EN, UPD_DONE, UPD_BUSY},
                {ecs, ewe, eaddr, (ewe ? pe : 8'd0), (k == n), 1'b1});
            if (poke && k == 2) begin
                UPD_START = 1'b1;
                UPD_LEN   = 13'd1;
                UPD_BASE  = ~base;
            end else begin
                UPD_START = 1'b0;
            end
            step();
        end
        chk("sweep_idle", {UPD_BUSY, UPD_DONE, CS}, 3'b000);
    endtask

    initial begin
        logic [12:0] a;
        logic [12:0] base;
        logic [12:0] sa;
        logic [7:0]  pe;
        logic        got;
        int          c0;
        int          d0;
        logic [12:0] exp_wr [$];
        logic [7:0]  exp_pe [$];

        RST = 1'b1; gate = 1'b0; SPI_REQ = 1'b0; SPI_WR = 1'b0; SPI_ADDR = '0;
        UPD_START = 1'b0; UPD_BASE = '0; UPD_LEN = '0; UPD_PRE_EN = '0;
        repeat (3) step();
        chk("reset_outs", {CS, WE, ADDR, PRE_EN, LANE, SPI_ACK, UPD_DONE, UPD_BUSY, SPI_RDATA}, 64'd0);
        RST = 1'b0;
        step();
        chk("idle_outs", {CS, WE, ADDR, PRE_EN, LANE, SPI_ACK, UPD_DONE, UPD_BUSY, SPI_RDATA}, 64'd0);

        // Directed SPI write and read
        gate = 1'b1;
        spi_op(1'b1, 2'd2, 13'h0123, 1'b0);
        mem[5] = 32'hA1B2C3D4;
        spi_op(1'b0, 2'd1, 13'h0005, 1'b0);
        chk("read_byte_c3", 64'(SPI_RDATA), 64'hC3);

        for (int i = 0; i < 6; i++) begin
            a = 13'($urandom_range(0, 8191));
            mem[a] = $urandom;
            spi_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, 1'b0);
        end

        // SPI request without gate must wait
        gate = 1'b0; SPI_REQ = 1'b1; SPI_WR = 1'b0; SPI_ADDR = {2'd3, 13'h0005};
        c0 = n_cs; d0 = n_ack;
        repeat (4) step();
        chk("nogate_no_cs", 64'(n_cs - c0), 64'd0);
        chk("nogate_no_ack", 64'(n_ack - d0), 64'd0);
        gate = 1'b1;
        spi_op(1'b0, 2'd3, 13'h0005, 1'b0);

        // Sweeps, including a wrap at the top of the array and back-to-back starts
        sweep(13'h1FFE, 13'd4, 8'hA5, 1'b0);
        sweep(13'($urandom_range(0, 8191)), 13'd0, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            base = (i % 2 == 0) ? 13'($urandom_range(8188, 8191)) : 13'($urandom_range(0, 8191));
            sweep(base, 13'($urandom_range(0, 5)), 8'($urandom), 1'(i % 2));
        end

        // Start with gate high is ignored
        gate = 1'b1; c0 = n_cs; d0 = n_done;
        UPD_START = 1'b1; UPD_LEN = 13'd3; UPD_BASE = 13'h0040; UPD_PRE_EN = 8'hFF;
        step();
        UPD_START = 1'b0;
        chk("gated_start_busy", 64'(UPD_BUSY), 64'd0);
        repeat (3) step();
        chk("gated_start_cs", 64'(n_cs - c0), 64'd0);
        chk("gated_start_done", 64'(n_done - d0), 64'd0);

        // Suspend during word 1, SPI write while suspended, then resume
        base = 13'($urandom_range(0, 8191));
        pe   = 8'($urandom_range(1, 255));
        sa   = 13'($urandom_range(0, 8191));
        gate = 1'b0;
        wr_log.delete(); pe_log.delete();
        UPD_START = 1'b1; UPD_BASE = base; UPD_LEN = 13'd4; UPD_PRE_EN = pe;
        step();
        UPD_START = 1'b0;
        step();
        step();
        chk("susp_w1_rd", {CS, WE, ADDR}, {1'b1, 1'b0, 13'(base + 13'd1)});
        gate = 1'b1;
        step();
        chk("susp_w1_wr", {CS, WE, ADDR}, {1'b1, 1'b1, 13'(base + 13'd1)});
        step();
        chk("susp_state", {CS, UPD_BUSY, UPD_DONE}, 3'b010);
        spi_op(1'b1, 2'($urandom_range(0, 3)), sa, 1'b1);
        chk("susp_after_spi", {CS, UPD_BUSY}, 2'b01);
        step();
        chk("susp_hold", {CS, UPD_BUSY}, 2'b01);
        gate = 1'b0;
        step();
        chk("resume_addr", {CS, WE, ADDR}, {1'b1, 1'b0, 13'(base + 13'd2)});
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (UPD_DONE) got = 1'b1;
        end
        chk("susp_done_seen", 64'(got), 64'd1);
        exp_wr = '{base, 13'(base + 13'd1), sa, 13'(base + 13'd2), 13'(base + 13'd3)};
        exp_pe = '{pe, pe, 8'd0, pe, pe};
        chk("susp_wr_count", 64'(wr_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            chk("susp_wr_addr", 64'(wr_log[i]), 64'(exp_wr[i]));
            chk("susp_wr_pre_en", 64'(pe_log[i]), 64'(exp_pe[i]));
        end
        step();
        chk("susp_idle", 64'(UPD_BUSY), 64'd0);

        // Reset during S_WR
        gate = 1'b1; d0 = n_ack;
        SPI_REQ = 1'b1; SPI_WR = 1'b1; SPI_ADDR = {2'd1, 13'h0ABC};
        step();
        step();
        chk("rst_in_swr", {CS, WE}, 2'b11);
        RST = 1'b1; SPI_REQ = 1'b0;
        step();
        chk("rst_mid_outs", {CS, WE, ADDR, PRE_EN, LANE, SPI_ACK, UPD_DONE, UPD_BUSY, SPI_RDATA}, 64'd0);
        RST = 1'b0;
        step();
        chk("rst_no_ack", 64'(n_ack - d0), 64'd0);
        a = 13'($urandom_range(0, 8191));
        mem[a] = $urandom;
        spi_op(1'b0, 2'($urandom_range(0, 3)), a, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/synarray_sched.md
# synarray_sched

Sequencer and arbiter for the 8192×32 synaptic SRAM inside the synaptic core. It generates the SRAM chip-select, write-enable and address, plus the per-lane update enables and the SPI byte-lane select. It shares the array between two requesters: SPI configuration accesses (byte read/write) and learning update sweeps. Each sweep is a read-modify-write pass over a contiguous word range. It sits between the top-level controller/SPI slave and the synaptic core, and never touches write data, which the core muxes itself.

## Interface
- ADDR_W, 13, SRAM word-address width (8192 words).
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SPI_GATE_ACTIVITY_sync  in  1  1 = SPI owns the array, learning suspended; 0 = learning allowed.
- SPI_REQ  in  1  SPI access request; level, held until SPI_ACK.
- SPI_WR  in  1  1 = byte write, 0 = byte read; stable while SPI_REQ.
- SPI_ADDR  in  15  [14:13] byte lane, [12:0] word address; stable while SPI_REQ.
- SPI_ACK  out  1  one-cycle completion pulse.
- SPI_RDATA  out  8  read byte; valid while SPI_ACK, held until the next read.
- UPD_START  in  1  one-cycle sweep start pulse.
- UPD_BASE  in  ADDR_W  first word address of the sweep.
- UPD_LEN  in  ADDR_W  words to process; 0 = no-op.
- UPD_PRE_EN  in  8  per-synapse-lane update enable, latched at start.
- UPD_BUSY  out  1  sweep accepted and not yet done.
- UPD_DONE  out  1  one-cycle sweep-complete pulse.
- SYNARRAY_RDATA  in  32  SRAM Q; registered, valid the cycle after a CS read.
- CTRL_SYNARRAY_CS  out  1  SRAM chip select.
- CTRL_SYNARRAY_WE  out  1  SRAM write enable.
- CTRL_SYNARRAY_ADDR  out  ADDR_W  SRAM word address.
- CTRL_PRE_EN  out  8  lane enables to the SDSP update logic.
- CTRL_SPI_ADDR  out  2  byte lane for the core's SPI write mux.

## Operation
- **States:** IDLE, S_RD, S_WR, S_RWAIT, S_ACK, U_RD, U_WR, U_SUSP, U_DONE. All outputs are registered Moore decodes.
- **IDLE:**
  - If SPI_REQ=1 and gate=1, latch lane/addr/wr and go to S_RD.
  - Otherwise, if UPD_START=1 and gate=0, latch base/len/pre_en and clear the word counter. Go to U_DONE if len=0, else to U_RD.
  - UPD_START in any other state or with gate=1 is ignored: no BUSY, no DONE.
- **SPI path:**
  - S_RD: CS=1, WE=0, ADDR=word. Next state is S_WR if write, else S_RWAIT.
  - S_WR: CS=1, WE=1, same ADDR. The core merges the byte into the read word.
  - S_RWAIT: CS=0. Capture SYNARRAY_RDATA[8·lane+7 : 8·lane] into SPI_RDATA.
  - S_ACK: SPI_ACK=1. SPI_REQ is not sampled here. Return to U_SUSP if entered from it, else IDLE.
  - CTRL_SPI_ADDR holds the latched lane from S_RD through S_ACK.
- **Update path:**
  - U_RD: CS=1, WE=0, ADDR=(base+cnt) mod 2^ADDR_W. The address wraps at 8191→0.
  - U_WR: CS=1, WE=1, same ADDR, CTRL_PRE_EN=latched pre_en. CTRL_PRE_EN is 0 in every other state. At the end of U_WR, cnt increments.
  - After U_WR, the next state is chosen in this order:
    - U_DONE if cnt+1=len;
    - else U_SUSP if gate=1;
    - else U_RD.
  - U_SUSP: CS=0. Serve SPI requests exactly as from IDLE. Go to U_RD (next word) when gate=0 and no SPI access is in flight.
  - U_DONE: UPD_DONE=1, then IDLE.
- **UPD_BUSY:** 1 in U_RD, U_WR, U_SUSP, U_DONE, and in SPI states entered from U_SUSP.
- **Priority:** a word RMW (U_RD→U_WR) is never split. A gate rise only takes effect at a word boundary.

## Timing
- **Reset:** all outputs 0, state IDLE, latched fields and counter 0.
- **Reset mid-operation:** CS/WE drop from the cycle after the reset edge. No ACK/DONE is produced, and the in-flight sweep is discarded.
- **SPI latency:** with SPI_REQ sampled at edge 0, cycle 1 is S_RD, cycle 2 is S_WR/S_RWAIT, and cycle 3 has SPI_ACK=1. This holds for both reads and writes.
- **SPI handshake:** the requester must drop SPI_REQ before the edge ending the cycle after ACK. A request still high then is treated as a new access.
- **SPI without gate:** SPI_REQ with gate=0 waits without ACK until gate=1 and the controller is in IDLE/U_SUSP.
- **Sweep timing:** 2 cycles per word when uninterrupted. A start accepted at edge 0 with len=L gives UPD_DONE in cycle 2L+1 and UPD_BUSY in cycles 1..2L+1. With len=0, UPD_DONE is in cycle 1.
- **Back-to-back:** a new UPD_START is accepted from the cycle after U_DONE.

## Test plan
- **SPI write:** SPI_ADDR={2'd2,13'h0123}, WR=1 -> cycles 1–2 have CS=1, ADDR=0x0123, WE=0 then 1. CTRL_SPI_ADDR=2 throughout. SPI_ACK=1 in cycle 3 only.
- **SPI read:** SRAM word 0x0005=0xA1B2C3D4, lane 1, WR=0 -> SPI_RDATA=0xC3 with SPI_ACK in cycle 3. WE stays 0.
- **Wrapping sweep:** base=0x1FFE, len=4, pre_en=0xA5, gate=0 -> addresses 1FFE,1FFF,0000,0001, each one RD then one WR cycle. CTRL_PRE_EN=0xA5 only in WR cycles. UPD_DONE in cycle 9; BUSY in cycles 1–9.
- **Suspend/resume:** len=4 sweep, gate rises during word 1 RD -> word 1 WR completes, then U_SUSP. An SPI write is served (ACK) with BUSY=1. After gate falls, word 2 resumes at base+2. Exactly 4 WR cycles in total.
- **Ignored starts:** len=0 -> UPD_DONE next cycle with no CS. A second UPD_START while BUSY, or UPD_START with gate=1, causes no extra DONE and no SRAM access.
- **Reset mid-access:** RST asserted during S_WR -> next cycle all outputs 0, no SPI_ACK. A subsequent SPI read completes normally in 3 cycles.
